data_mem_responder: RTL and testbench
=====================================

DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter WORDS, default 16: number of 32-bit words in the internal array.
REQ-002 Parameter LATENCY, default 2 (legal 1..7): cycles per array access, read or drain.
REQ-003 Parameter WB_DEPTH, default 2: number of posted-write buffer entries.
REQ-004 CLK  input  1  clock; all state updates on the falling edge, as in the processor core.
REQ-005 Reset  input  1  synchronous, active-high reset, sampled on the falling edge of CLK.
REQ-006 MemoryRead  input  1  read request from the MEM stage.
REQ-007 MemoryWrite  input  1  write request from the MEM stage.
REQ-008 Address  input  6  byte address; word index = Address[5:2]; Address[1:0] ignored.
REQ-009 WriteData  input  32  write data.
REQ-010 ReadData  output  32  read data, valid while Ready=1 during a read.
REQ-011 Ready  output  1  0 = stall; the request is accepted on an edge where a request is high and Ready=1.
REQ-012 ProtocolErr  output  1  sticky error flag.

Function
REQ-013 The requester holds all inputs stable while Ready=0; the responder relies on this and does not latch the request early.
REQ-014 The state machine has three states: IDLE, RD_WAIT and RD_DONE.
REQ-015 IDLE with no request: Ready=1 and ReadData holds its last value.
REQ-016 IDLE read, buffer hit (any valid entry matching the word index): Ready=1 and ReadData = youngest matching entry, combinationally, with zero stall.
REQ-017 IDLE read, buffer miss: Ready=0, load the latency counter, and go to RD_WAIT.
REQ-018 RD_WAIT: Ready=0 for exactly LATENCY cycles counted from the miss cycle; then capture the array word into the read register and go to RD_DONE.
REQ-019 RD_DONE: Ready=1 and ReadData = read register; return to IDLE on the next edge.
REQ-020 Write accepted when not full: Ready=1 and the entry {index, data} is appended at the tail.
REQ-021 Write while the buffer is full: Ready=0 until a drain frees an entry.
REQ-022 A drain and a write accept may occur on the same edge; occupancy is then unchanged.
REQ-023 Drain: while the buffer is non-empty and the state is IDLE, the oldest entry is written to the array after LATENCY cycles, then removed.
REQ-024 Drain pauses during RD_WAIT and RD_DONE; it resumes with its counter preserved.
REQ-025 Duplicate addresses in the buffer are allowed; drains occur in order, so the youngest value wins in the array.
REQ-026 The head and tail pointers wrap modulo WB_DEPTH; occupancy is tracked with a count of 0..WB_DEPTH.
REQ-027 MemoryRead and MemoryWrite both high is illegal: the request is handled as a write and ProtocolErr is set until Reset.

Reset
REQ-028 On Reset, all array words are set to 0, the buffer is emptied, state = IDLE, counters = 0, ReadData = 0, ProtocolErr = 0, and Ready = 1.
REQ-029 Reset during RD_WAIT or RD_DONE aborts the read; Reset with a non-empty buffer discards the pending writes.
REQ-030 Reset has priority over every simultaneous request or drain.

Verification
REQ-031 Reset, then read 0x08 -> Ready low for 2 cycles, then Ready=1 with ReadData=0x00000000.
REQ-032 Write 0x04=0xDEADBEEF, then read 0x04 on the next cycle -> Ready=1 immediately with ReadData=0xDEADBEEF (forwarded from the buffer).
REQ-033 Three back-to-back writes to 0x00, 0x04 and 0x08 -> the third sees Ready=0 until the first drains (2 cycles); afterwards, reading each address returns the correct data.
REQ-034 Write 0x0C=1, then write 0x0C=2, then wait 6 cycles and read 0x0C via a miss -> ReadData=2.
REQ-035 MemoryRead=MemoryWrite=1 at 0x10 with data 0x55 -> ProtocolErr=1 and a later read of 0x10 returns 0x55; Reset -> ProtocolErr=0.
REQ-036 Assert Reset in the middle of RD_WAIT with one buffered write -> the next cycle shows Ready=1, ReadData=0, and a read of the buffered address returns 0.

Source files
------------

// File: rtl/data_mem_responder.sv
// Data-memory responder with a posted-write buffer and multi-cycle array reads.
// Reads forward from the buffer on a hit; misses stall for LATENCY cycles.
module data_mem_responder #(
    parameter int WORDS    = 16,
    parameter int LATENCY  = 2,
    parameter int WB_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        MemoryRead,
    input  logic        MemoryWrite,
    input  logic [5:0]  Address,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        Ready,
    output logic        ProtocolErr
);
    localparam int PW = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
    localparam int CW = $clog2(WB_DEPTH + 1);
    localparam logic [2:0] LAST = 3'(LATENCY - 1);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RD_DONE} state_t;
    state_t state, nextState;

    logic [31:0]   mem    [WORDS];
    logic [3:0]    wbIdx  [WB_DEPTH];
    logic [31:0]   wbData [WB_DEPTH];
    logic [PW-1:0] wbHead, wbTail, pos;
    logic [CW-1:0] wbCount;
    logic [2:0]    rdCnt, drCnt;
    logic [31:0]   readReg, fwdData;
    logic [3:0]    wordIdx;
    logic          fwdHit, wrAccept, missLoad, capture, rdHit;
    logic          drainTick, drainDone, wbFull;
    logic          unusedAddr;

    assign wordIdx    = Address[5:2];
    assign unusedAddr = ^Address[1:0];
    assign wbFull     = (int'(wbCount) == WB_DEPTH);
    assign drainTick  = (state == IDLE) && (wbCount != '0);
    assign drainDone  = drainTick && (drCnt == LAST);

    function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] p);
        return (int'(p) == WB_DEPTH - 1) ? '0 : p + 1'b1;
    endfunction

    // Walk oldest to youngest so the youngest match wins
    always_comb begin
        fwdHit  = 1'b0;
        fwdData = '0;
        pos     = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            pos = PW'((int'(wbHead) + i) % WB_DEPTH);
            if (i < int'(wbCount) && wbIdx[pos] == wordIdx) begin
                fwdHit  = 1'b1;
                fwdData = wbData[pos];
            end
        end
    end

    always_comb begin
        nextState = state;
        Ready     = 1'b1;
        ReadData  = readReg;
        wrAccept  = 1'b0;
        missLoad  = 1'b0;
        capture   = 1'b0;
        rdHit     = 1'b0;
        unique case (state)
            IDLE: begin
                if (MemoryWrite) begin
                    Ready    = !wbFull;
                    wrAccept = !wbFull;
                end else if (MemoryRead) begin
                    if (fwdHit) begin
                        ReadData = fwdData;
                        rdHit    = 1'b1;
                    end else begin
                        Ready     = 1'b0;
                        missLoad  = 1'b1;
                        capture   = (LATENCY == 1);
                        nextState = (LATENCY == 1) ? RD_DONE : RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                Ready = 1'b0;
                if (rdCnt <= 3'd1) begin
                    capture   = 1'b1;
                    nextState = RD_DONE;
                end
            end
            RD_DONE: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(negedge CLK) begin
        if (Reset) state <= IDLE;
        else       state <= nextState;
    end

    always_ff @(negedge CLK) begin
        if (Reset) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= '0;
            wbHead      <= '0;
            wbTail      <= '0;
            wbCount     <= '0;
            rdCnt       <= '0;
            drCnt       <= '0;
            readReg     <= '0;
            ProtocolErr <= 1'b0;
        end else begin
            if (MemoryRead && MemoryWrite) ProtocolErr <= 1'b1;
            if (missLoad)               rdCnt <= LAST;
            else if (state == RD_WAIT)  rdCnt <= rdCnt - 3'd1;
            if (capture)    readReg <= mem[wordIdx];
            else if (rdHit) readReg <= fwdData;
            // Drain counter only advances in IDLE, so it survives a read
            if (drainTick) begin
                if (drainDone) begin
                    mem[wbIdx[wbHead]] <= wbData[wbHead];
                    wbHead <= nextPtr(wbHead);
                    drCnt  <= '0;
                end else begin
                    drCnt <= drCnt + 3'd1;
                end
            end
            if (wrAccept) wbTail <= nextPtr(wbTail);
            if (wrAccept && !drainDone)      wbCount <= wbCount + 1'b1;
            else if (!wrAccept && drainDone) wbCount <= wbCount - 1'b1;
        end
    end

    always_ff @(negedge CLK) begin
        if (!Reset && wrAccept) begin
            wbIdx[wbTail]  <= wordIdx;
            wbData[wbTail] <= WriteData;
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed scenarios plus random traffic
// checked every cycle against a queue-based behavioural model.
module tb_data_mem_responder;
    localparam int LAT = 2;
    localparam int WBD = 2;

    logic        CLK;
    logic        Reset;
    logic        MemoryRead;
    logic        MemoryWrite;
    logic [5:0]  Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Ready;
    logic        ProtocolErr;

    int nErr = 0;
    int nChecks = 0;

    data_mem_responder #(.WORDS(16), .LATENCY(LAT), .WB_DEPTH(WBD)) dut (
        .CLK(CLK), .Reset(Reset), .MemoryRead(MemoryRead),
        .MemoryWrite(MemoryWrite), .Address(Address), .WriteData(WriteData),
        .ReadData(ReadData), .Ready(Ready), .ProtocolErr(ProtocolErr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Behavioural model: array, FIFO of pending writes, stall count of a read
    typedef struct {
        logic [3:0]  idx;
        logic [31:0] data;
    } ent_t;

    logic [31:0] mMem [16];
    ent_t        mQ [$];
    int          mDrain;
    int          mStall;
    bit          mDone;
    logic [31:0] mLast;
    bit          mErr;
    bit          live = 1'b0;

    function automatic void expectOut(output bit eRdy, output logic [31:0] eData);
        bit found;
        eRdy  = 1'b1;
        eData = mLast;
        found = 1'b0;
        if (mDone) begin
            eRdy = 1'b1;
        end else if (mStall > 0) begin
            eRdy = 1'b0;
        end else if (MemoryWrite) begin
            eRdy = (mQ.size() < WBD);
        end else if (MemoryRead) begin
            for (int i = mQ.size() - 1; i >= 0; i--) begin
                if (!found && mQ[i].idx == Address[5:2]) begin
                    eData = mQ[i].data;
                    found = 1'b1;
                end
            end
            eRdy = found;
        end
    endfunction

    always @(negedge CLK) begin : model
        bit          idle;
        bit          wAcc;
        bit          eR;
        logic [31:0] eD;
        logic [3:0]  ix;
        if (Reset) begin
            for (int i = 0; i < 16; i++) mMem[i] = '0;
            mQ.delete();
            mDrain = 0;
            mStall = 0;
            mDone  = 1'b0;
            mLast  = '0;
            mErr   = 1'b0;
            live   = 1'b1;
        end else if (live) begin
            ix   = Address[5:2];
            idle = !mDone && mStall == 0;
            expectOut(eR, eD);
            wAcc = idle && MemoryWrite && eR;
            if (MemoryRead && MemoryWrite) mErr = 1'b1;
            if (mDone) begin
                mDone = 1'b0;
            end else if (mStall > 0) begin
                mStall++;
                if (mStall == LAT) begin
                    mLast = mMem[ix];
                    mDone = 1'b1;
                    mStall = 0;
                end
            end else if (MemoryRead && !MemoryWrite) begin
                if (eR) begin
                    mLast = eD;
                end else begin
                    mStall = 1;
                    if (LAT == 1) begin
                        mLast = mMem[ix];
                        mDone = 1'b1;
                        mStall = 0;
                    end
                end
            end
            if (idle && mQ.size() > 0) begin
                mDrain++;
                if (mDrain == LAT) begin
                    mMem[mQ[0].idx] = mQ[0].data;
                    void'(mQ.pop_front());
                    mDrain = 0;
                end
            end
            if (wAcc) mQ.push_back('{ix, WriteData});
        end
    end

    always @(posedge CLK) begin : compare
        bit          eR;
        logic [31:0] eD;
        if (live) begin
            expectOut(eR, eD);
            chk("ready", {31'b0, Ready}, {31'b0, eR});
            chk("perr", {31'b0, ProtocolErr}, {31'b0, mErr});
            if (eR && !MemoryWrite) chk("rdata", ReadData, eD);
        end
    end

    task automatic req(input bit rd, input bit wr, input logic [5:0] a,
                       input logic [31:0] d, output int stalls,
                       output logic [31:0] got);
        bit r;
        MemoryRead  = rd;
        MemoryWrite = wr;
        Address     = a;
        WriteData   = d;
        stalls      = 0;
        got         = '0;
        for (int n = 0; n < 40; n++) begin
            @(posedge CLK);
            r   = Ready;
            got = ReadData;
            @(negedge CLK);
            #1;
            if (r) begin
                MemoryRead  = 1'b0;
                MemoryWrite = 1'b0;
                return;
            end
            stalls++;
        end
        nChecks++;
        nErr++;
        $display("FAIL req_timeout: got no Ready expected Ready within 40 cycles");
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge CLK);
        #1;
    endtask

    task automatic doReset();
        Reset       = 1'b1;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        @(negedge CLK);
        #1;
        Reset = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          st, s0, s1, s2;
        logic [31:0] d;
        Reset       = 1'b1;
        MemoryRead  = 1'b0;
        MemoryWrite = 1'b0;
        Address     = '0;
        WriteData   = '0;
        @(negedge CLK);
        #1;
        Reset = 1'b0;
        @(posedge CLK);
        chk("rst_ready", {31'b0, Ready}, 32'd1);
        chk("rst_rdata", ReadData, 32'd0);
        chk("rst_perr", {31'b0, ProtocolErr}, 32'd0);
        @(negedge CLK);
        #1;

        req(1'b1, 1'b0, 6'h08, 32'd0, st, d);
        chk("miss_stall", 32'(st), 32'd2);
        chk("miss_data", d, 32'd0);

        req(1'b0, 1'b1, 6'h04, 32'hDEADBEEF, st, d);
        req(1'b1, 1'b0, 6'h04, 32'd0, st, d);
        chk("fwd_stall", 32'(st), 32'd0);
        chk("fwd_data", d, 32'hDEADBEEF);

        doReset();
        req(1'b0, 1'b1, 6'h00, 32'h1111_0000, s0, d);
        req(1'b0, 1'b1, 6'h04, 32'h2222_0004, s1, d);
        req(1'b0, 1'b1, 6'h08, 32'h3333_0008, s2, d);
        chk("full_w0", 32'(s0), 32'd0);
        chk("full_w1", 32'(s1), 32'd0);
        chk("full_w2", 32'(s2), 32'd1);
        req(1'b1, 1'b0, 6'h00, 32'd0, st, d);
        chk("full_r0", d, 32'h1111_0000);
        req(1'b1, 1'b0, 6'h04, 32'd0, st, d);
        chk("full_r1", d, 32'h2222_0004);
        req(1'b1, 1'b0, 6'h08, 32'd0, st, d);
        chk("full_r2", d, 32'h3333_0008);
        idle(8);

        req(1'b0, 1'b1, 6'h0C, 32'd1, st, d);
        req(1'b0, 1'b1, 6'h0C, 32'd2, st, d);
        idle(6);
        req(1'b1, 1'b0, 6'h0C, 32'd0, st, d);
        chk("dup_stall", 32'(st), 32'd2);
        chk("dup_data", d, 32'd2);

        doReset();
        req(1'b1, 1'b1, 6'h10, 32'h55, st, d);
        @(posedge CLK);
        chk("perr_set", {31'b0, ProtocolErr}, 32'd1);
        @(negedge CLK);
        #1;
        req(1'b1, 1'b0, 6'h10, 32'd0, st, d);
        chk("perr_data", d, 32'h55);
        doReset();
        @(posedge CLK);
        chk("perr_clr", {31'b0, ProtocolErr}, 32'd0);
        @(negedge CLK);
        #1;

        req(1'b0, 1'b1, 6'h14, 32'h77, st, d);
        MemoryRead = 1'b1;
        Address    = 6'h18;
        @(posedge CLK);
        chk("abort_miss", {31'b0, Ready}, 32'd0);
        @(negedge CLK);
        #1;
        Reset = 1'b1;
        @(negedge CLK);
        #1;
        Reset      = 1'b0;
        MemoryRead = 1'b0;
        @(posedge CLK);
        chk("abort_ready", {31'b0, Ready}, 32'd1);
        chk("abort_rdata", ReadData, 32'd0);
        @(negedge CLK);
        #1;
        req(1'b1, 1'b0, 6'h14, 32'd0, st, d);
        chk("abort_drop", d, 32'd0);

        for (int k = 0; k < 400; k++) begin
            int          op;
            logic [5:0]  a;
            op = int'($urandom_range(0, 19));
            a  = {1'b0, 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            if (op < 8)        req(1'b1, 1'b0, a, 32'd0, st, d);
            else if (op < 16)  req(1'b0, 1'b1, a, $urandom, st, d);
            else if (op < 18)  idle(int'($urandom_range(1, 3)));
            else if (op == 18) req(1'b1, 1'b1, a, $urandom, st, d);
            else               doReset();
        end

        idle(3);
        $display("Result: errors=%0d of %0d checks", nErr, nChecks);
        $finish;
    end
endmodule
